// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants and the shared coordinate type
package vga_timing_pkg;
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BACK = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BACK = 33;
  localparam int H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  typedef logic [9:0] coord_t;
endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// wrap_counter: enabled up-counter that wraps to 0 after MAX, with a combinational at_max flag
module wrap_counter #(
  parameter int WIDTH = 10,
  parameter int MAX = 799
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] value,
  output logic             at_max
);
  assign at_max = value == WIDTH'(MAX);
  // advance on inc, returning to 0 after MAX
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) value <= '0;
    else if (inc) value <= at_max ? '0 : value + WIDTH'(1);
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters with registered syncs, blanking and line/frame strobes
// Define VGA_FRAME_CNT_EN to add the 8-bit frame_count output.
module vga_timing_gen import vga_timing_pkg::*; #(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT = DEF_H_FRONT,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BACK = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT = DEF_V_FRONT,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BACK = DEF_V_BACK,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   ena,
  output coord_t pix_x,
  output coord_t pix_y,
  output logic   hsync,
  output logic   vsync,
  output logic   display_on,
  output logic   line_start,
  output logic   frame_start
`ifdef VGA_FRAME_CNT_EN
  , output logic [7:0] frame_count
`endif
);
  localparam int HT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam coord_t H_VIS = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS = coord_t'(V_DISPLAY);
  localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_END = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_END = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  if (HT > 1024 || VT > 1024 || H_DISPLAY == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_DISPLAY == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_timing
    $error("vga_timing_gen: timing parameters out of range");
  end
  logic h_max, v_max;
  coord_t nx, ny;
  wrap_counter #(.WIDTH($bits(coord_t)), .MAX(HT - 1)) u_h (
    .clk(clk), .rst_n(rst_n), .inc(ena), .value(pix_x), .at_max(h_max)
  );
  wrap_counter #(.WIDTH($bits(coord_t)), .MAX(VT - 1)) u_v (
    .clk(clk), .rst_n(rst_n), .inc(h_max && ena), .value(pix_y), .at_max(v_max)
  );
  // decodes look at the coordinate the counters are about to take, so they line up with it
  assign nx = !ena ? pix_x : h_max ? '0 : pix_x + coord_t'(1);
  assign ny = !(ena && h_max) ? pix_y : v_max ? '0 : pix_y + coord_t'(1);
  // registered syncs, blanking and strobes; everything freezes while ena is low
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hsync <= !SYNC_POL;
      vsync <= !SYNC_POL;
      display_on <= 1'b0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
    end else if (ena) begin
      hsync <= (nx >= HS_START && nx <= HS_END) ? SYNC_POL : !SYNC_POL;
      vsync <= (ny >= VS_START && ny <= VS_END) ? SYNC_POL : !SYNC_POL;
      display_on <= nx < H_VIS && ny < V_VIS;
      line_start <= nx == '0;
      frame_start <= nx == '0 && ny == '0;
    end
`ifdef VGA_FRAME_CNT_EN
  // counts completed frames on the edge where both counters wrap
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) frame_count <= '0;
    else if (ena && h_max && v_max) frame_count <= frame_count + 8'd1;
`endif
endmodule
